// File: rtl/p_hit_sched.sv
// Ray/triangle issue sequencer for the p_hit datapath.
// Tags each issued triangle with its index and re-pairs results in order.
module p_hit_sched #(
  parameter int IDX_W        = 16,
  parameter int MAX_INFLIGHT = 8,
  parameter int TAG_DEPTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ray_empty,
  output logic                    ray_rd_en,
  input  logic signed [31:0]      ray_origin [2:0],
  input  logic signed [31:0]      ray_dir [2:0],
  input  logic [IDX_W-1:0]        ray_num_tris,
  input  logic                    tri_empty,
  output logic                    tri_rd_en,
  input  logic signed [31:0]      tri_normal [2:0],
  input  logic signed [31:0]      tri_v0 [2:0],
  output logic signed [31:0]      ph_normal [2:0],
  output logic signed [31:0]      ph_v0 [2:0],
  output logic signed [31:0]      ph_origin [2:0],
  output logic signed [31:0]      ph_dir [2:0],
  input  logic [3:0]              ph_in_full,
  output logic [3:0]              ph_in_wr_en,
  input  logic signed [31:0]      ph_out [2:0],
  input  logic                    ph_out_empty,
  output logic                    ph_out_rd_en,
  output logic signed [31:0]      out_point [2:0],
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_empty,
  input  logic                    out_rd_en,
  output logic                    busy,
  output logic                    done
);

  localparam int TW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IDX_W-1:0] ONE  = 1;
  localparam logic [CW-1:0]    MAXI = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic signed [31:0] org_q [2:0];
  logic signed [31:0] dir_q [2:0];
  logic [IDX_W-1:0]   ntri_q;
  logic [IDX_W-1:0]   iss_idx;
  logic [IDX_W-1:0]   ret_cnt;
  logic [CW-1:0]      inflight;
  logic [IDX_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TW-1:0]      wr_ptr;
  logic [TW-1:0]      rd_ptr;

  logic active, accept, fire, tag_vld, rfire;

  // Tags track issued-not-retired triangles one-for-one with inflight.
  assign tag_vld = (inflight != '0);
  assign active  = (state_q == ISSUE) || (state_q == DRAIN);
  assign accept  = !reset && (state_q == IDLE) && !ray_empty;
  assign fire    = !reset && (state_q == ISSUE) && !tri_empty
                && (ph_in_full == 4'b0000) && (inflight < MAXI);
  assign rfire   = !reset && active && !ph_out_empty && tag_vld
                && (out_empty || out_rd_en);

  assign ph_origin = org_q;
  assign ph_dir    = dir_q;
  assign ph_normal = tri_normal;
  assign ph_v0     = tri_v0;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept)
               state_d = (ray_num_tris == '0) ? DONE : ISSUE;
      ISSUE: if (fire && (iss_idx == ntri_q - ONE))
               state_d = DRAIN;
      DRAIN: if (ret_cnt == ntri_q)
               state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ray_rd_en    = accept;
    tri_rd_en    = fire;
    ph_in_wr_en  = {4{fire}};
    ph_out_rd_en = rfire;
    busy         = !reset && (state_q != IDLE);
    done         = !reset && (state_q == DONE);
  end

  always_ff @(posedge clock) begin
    if (fire) tag_mem[wr_ptr] <= iss_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      org_q     <= '{default: '0};
      dir_q     <= '{default: '0};
      ntri_q    <= '0;
      iss_idx   <= '0;
      ret_cnt   <= '0;
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_point <= '{default: '0};
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_empty <= 1'b1;
    end else begin
      if (accept) begin
        org_q   <= ray_origin;
        dir_q   <= ray_dir;
        ntri_q  <= ray_num_tris;
        iss_idx <= '0;
        ret_cnt <= '0;
      end
      if (fire) begin
        wr_ptr  <= wr_ptr + TW'(1);
        iss_idx <= iss_idx + ONE;
      end
      // Reload wins over consume so read+reload costs no bubble.
      if (rfire) begin
        rd_ptr    <= rd_ptr + TW'(1);
        out_point <= ph_out;
        out_idx   <= tag_mem[rd_ptr];
        out_last  <= (ret_cnt == ntri_q - ONE);
        out_empty <= 1'b0;
        ret_cnt   <= ret_cnt + ONE;
      end else if (out_rd_en) begin
        out_empty <= 1'b1;
      end
      unique case ({fire, rfire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !ph_out_empty)
      assert (tag_vld);
  end

endmodule

// File: tb/tb_p_hit_sched.sv
// Directed bench for p_hit_sched with behavioural ray/tri FIFOs and p_hit.
// p_hit result per lane = normal + v0 + origin + dir of the issued triangle.
module tb_p_hit_sched;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic               ray_empty, ray_rd_en;
  logic signed [31:0] ray_origin [2:0];
  logic signed [31:0] ray_dir [2:0];
  logic [15:0]        ray_num_tris;
  logic               tri_empty, tri_rd_en;
  logic signed [31:0] tri_normal [2:0];
  logic signed [31:0] tri_v0 [2:0];
  logic signed [31:0] ph_normal [2:0];
  logic signed [31:0] ph_v0 [2:0];
  logic signed [31:0] ph_origin [2:0];
  logic signed [31:0] ph_dir [2:0];
  logic [3:0]         ph_in_full = 4'b0000;
  logic [3:0]         ph_in_wr_en;
  logic signed [31:0] ph_out [2:0];
  logic               ph_out_empty, ph_out_rd_en;
  logic signed [31:0] out_point [2:0];
  logic [15:0]        out_idx;
  logic               out_last, out_empty;
  logic               out_rd_en = 1'b0;
  logic               busy, done;

  p_hit_sched dut (
    .clock(clock), .reset(reset),
    .ray_empty(ray_empty), .ray_rd_en(ray_rd_en),
    .ray_origin(ray_origin), .ray_dir(ray_dir),
    .ray_num_tris(ray_num_tris),
    .tri_empty(tri_empty), .tri_rd_en(tri_rd_en),
    .tri_normal(tri_normal), .tri_v0(tri_v0),
    .ph_normal(ph_normal), .ph_v0(ph_v0),
    .ph_origin(ph_origin), .ph_dir(ph_dir),
    .ph_in_full(ph_in_full), .ph_in_wr_en(ph_in_wr_en),
    .ph_out(ph_out), .ph_out_empty(ph_out_empty),
    .ph_out_rd_en(ph_out_rd_en),
    .out_point(out_point), .out_idx(out_idx),
    .out_last(out_last), .out_empty(out_empty),
    .out_rd_en(out_rd_en), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(negedge clock) cyc++;

  int ray_nt[$];
  int ray_ob[$];
  int tri_b[$];
  logic [31:0] r0[$], r1[$], r2[$];

  int wr_cnt = 0, trd_cnt = 0, rrd_cnt = 0, done_cnt = 0;
  int fire_cyc[$];
  int last_ro_cyc = 0, ray_pop_cyc = 0, done_cyc = 0;

  int          log_idx[$];
  logic [95:0] log_pt[$];
  int          log_last[$];
  int          log_cyc[$];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void refresh();
    ray_empty    = (ray_nt.size() == 0);
    ray_num_tris = ray_empty ? 16'd0 : 16'(ray_nt[0]);
    tri_empty    = (tri_b.size() == 0);
    ph_out_empty = (r0.size() == 0);
    for (int k = 0; k < 3; k++) begin
      ray_origin[k] = ray_empty ? 0 : ray_ob[0] + k;
      ray_dir[k]    = 7 + k;
      tri_v0[k]     = tri_empty ? 0 : tri_b[0] + k;
      tri_normal[k] = tri_empty ? 0 : 2 * tri_b[0] + k;
    end
    ph_out[0] = ph_out_empty ? 0 : r0[0];
    ph_out[1] = ph_out_empty ? 0 : r1[0];
    ph_out[2] = ph_out_empty ? 0 : r2[0];
  endfunction

  // External FIFO and p_hit model: sample before the edge settles, update 1ns later.
  always @(posedge clock) begin
    logic rs, rr, tr, ro;
    logic [3:0] w, fl;
    logic [31:0] s [3];
    rs = reset; rr = ray_rd_en; tr = tri_rd_en;
    ro = ph_out_rd_en; w = ph_in_wr_en; fl = ph_in_full;
    for (int k = 0; k < 3; k++)
      s[k] = ph_normal[k] + ph_v0[k] + ph_origin[k] + ph_dir[k];
    #1;
    if (rr) begin
      void'(ray_nt.pop_front()); void'(ray_ob.pop_front());
      rrd_cnt++; ray_pop_cyc = cyc;
    end
    if (tr) begin
      void'(tri_b.pop_front()); trd_cnt++;
    end
    if (ro) begin
      void'(r0.pop_front()); void'(r1.pop_front()); void'(r2.pop_front());
      last_ro_cyc = cyc;
    end
    if (w != 4'b0000) begin
      chk("lanes", w, 4'b1111);
      chk("wr_full", fl, 4'b0000);
      wr_cnt++;
      fire_cyc.push_back(cyc);
      r0.push_back(s[0]); r1.push_back(s[1]); r2.push_back(s[2]);
    end
    if (rs) begin
      r0.delete(); r1.delete(); r2.delete();
    end
    refresh();
  end

  always @(posedge clock) begin
    if (!reset && out_rd_en && !out_empty) begin
      log_idx.push_back(int'(out_idx));
      log_pt.push_back({out_point[2], out_point[1], out_point[0]});
      log_last.push_back(int'(out_last));
      log_cyc.push_back(cyc);
    end
    if (!reset && done) begin
      done_cnt++; done_cyc = cyc;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_ray(int nt, int ob);
    ray_nt.push_back(nt); ray_ob.push_back(ob); refresh();
  endtask

  task automatic push_tris(int t, int n);
    for (int i = 0; i < n; i++) tri_b.push_back(t * 1000 + i * 10);
    refresh();
  endtask

  function automatic logic [95:0] exp_pt(int t, int i, int o);
    logic [31:0] p [3];
    int b;
    b = t * 1000 + i * 10;
    for (int k = 0; k < 3; k++) p[k] = 3 * b + o + 7 + 4 * k;
    return {p[2], p[1], p[0]};
  endfunction

  task automatic wait_done(int target, int budget);
    int c;
    c = 0;
    while (done_cnt < target && c < budget) begin
      tick(1); c++;
    end
    chk("done_cnt", done_cnt, target);
  endtask

  task automatic wait_wr(int target, int budget);
    int c;
    c = 0;
    while (wr_cnt < target && c < budget) begin
      tick(1); c++;
    end
    chk("wr_reach", wr_cnt, target);
  endtask

  task automatic check_log(int t, int n, int o);
    chk("log_size", log_idx.size(), n);
    for (int i = 0; i < n && i < log_idx.size(); i++) begin
      chk("idx", log_idx[i], i);
      chk("point", log_pt[i], exp_pt(t, i, o));
      chk("last", log_last[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic clear_logs();
    log_idx.delete(); log_pt.delete(); log_last.delete();
    log_cyc.delete(); fire_cyc.delete();
  endtask

  int w0, w1, t0, tsz;

  initial begin
    refresh();
    tick(3);
    chk("rst_out_empty", out_empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_ph_rd", ph_out_rd_en, 0);
    reset = 1'b0;
    tick(1);

    // three triangles, free-flowing
    clear_logs();
    out_rd_en = 1'b1;
    push_tris(1, 3);
    push_ray(3, 100000);
    wait_done(1, 100);
    check_log(1, 3, 100000);
    chk("t1_fires", fire_cyc.size(), 3);
    if (fire_cyc.size() == 3)
      chk("t1_consec", fire_cyc[2] - fire_cyc[0], 2);
    chk("t1_done_lat", done_cyc - last_ro_cyc, 2);
    tick(1);
    chk("t1_idle", busy, 0);

    // zero-triangle ray
    w0 = wr_cnt; t0 = trd_cnt;
    push_ray(0, 200000);
    wait_done(2, 20);
    chk("t2_ray_pop", rrd_cnt, 2);
    chk("t2_done_lat", done_cyc - ray_pop_cyc, 1);
    chk("t2_no_wr", wr_cnt, w0);
    chk("t2_no_tri", trd_cnt, t0);

    // one lane full mid-stream
    clear_logs();
    w0 = wr_cnt;
    push_tris(3, 5);
    push_ray(5, 300000);
    wait_wr(w0 + 2, 50);
    ph_in_full = 4'b0100;
    w1 = wr_cnt; tsz = tri_b.size();
    tick(5);
    chk("t3_stall_wr", wr_cnt, w1);
    chk("t3_stall_tri", tri_b.size(), tsz);
    ph_in_full = 4'b0000;
    wait_done(3, 100);
    check_log(3, 5, 300000);

    // inflight cap with output held
    clear_logs();
    out_rd_en = 1'b0;
    w0 = wr_cnt;
    push_tris(4, 20);
    push_ray(20, 400000);
    tick(40);
    chk("t4_issued", wr_cnt - w0, 9);
    chk("t4_out_full", out_empty, 0);
    chk("t4_out_idx", out_idx, 0);
    chk("t4_busy", busy, 1);
    out_rd_en = 1'b1;
    wait_done(4, 200);
    tick(3);
    chk("t4_done_once", done_cnt, 4);
    check_log(4, 20, 400000);

    // back-to-back consume and reload
    clear_logs();
    out_rd_en = 1'b0;
    push_tris(5, 4);
    push_ray(4, 500000);
    tick(15);
    out_rd_en = 1'b1;
    wait_done(5, 50);
    check_log(5, 4, 500000);
    if (log_cyc.size() == 4)
      chk("t5_b2b", log_cyc[3] - log_cyc[0], 3);

    // reset mid-ray
    clear_logs();
    out_rd_en = 1'b0;
    w0 = wr_cnt;
    push_tris(6, 5);
    push_ray(5, 600000);
    wait_wr(w0 + 2, 50);
    reset = 1'b1;
    tick(1);
    chk("t6_out_empty", out_empty, 1);
    chk("t6_busy", busy, 0);
    chk("t6_out_idx", out_idx, 0);
    chk("t6_out_pt", out_point[0], 0);
    chk("t6_out_last", out_last, 0);
    chk("t6_tri_rd", tri_rd_en, 0);
    chk("t6_wr_en", ph_in_wr_en, 0);
    tri_b.delete();
    refresh();
    reset = 1'b0;
    tick(1);
    clear_logs();
    out_rd_en = 1'b1;
    push_tris(7, 2);
    push_ray(2, 700000);
    wait_done(6, 50);
    check_log(7, 2, 700000);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
